// File: rtl/regfile_arb_pkg.sv
// Shared widths and constants for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // Register 0 is hardwired; writes to it are consumed but never issued.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bundle: per-requester valid/addr/data and the one-hot ready.
interface regfile_write_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching cyclically from ptr.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    int            pos;
    logic [IW-1:0] pos_i;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        pos_i = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            pos_i = IW'(pos);
            if (!any && req[pos_i]) begin
                any = 1'b1;
                idx = pos_i;
            end
        end
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port, with a registered
// write stage, saturating write counter and read-hazard flags for decode.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_arbiter_if.slave req,
    input  logic                 hold,
    input  logic [ADDR_W-1:0]    rd_addr1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [CNT_W-1:0]     write_count
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]  arb_req;
    logic [N_REQ-1:0]  grant;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    logic [IW-1:0]     ptr_q, ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Ready is independent of the output stage so grants can stream every cycle.
    assign arb_req = hold ? '0 : req.req_valid;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign req.req_ready = grant;

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_addr = req.req_addr[i*ADDR_W +: ADDR_W];
                gnt_data = req.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (gnt_any) begin
            ptr_d      = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            rf_we_d    = (gnt_addr != ADDR_W'(ZERO_REG));
            rf_waddr_d = gnt_addr;
            rf_wdata_d = gnt_data;
        end
        cnt_d = (rf_we_q && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            cnt_q      <= cnt_d;
        end
    end

    // A source is hazardous while any valid requester targets it or it sits in the write stage.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req.req_valid[i]) begin
                if (req.req_addr[i*ADDR_W +: ADDR_W] == rd_addr1) hazard1 = 1'b1;
                if (req.req_addr[i*ADDR_W +: ADDR_W] == rd_addr2) hazard2 = 1'b1;
            end
        end
        if (rf_we_q && (rf_waddr_q == rd_addr1)) hazard1 = 1'b1;
        if (rf_we_q && (rf_waddr_q == rd_addr2)) hazard2 = 1'b1;
        if (rd_addr1 == ADDR_W'(ZERO_REG)) hazard1 = 1'b0;
        if (rd_addr2 == ADDR_W'(ZERO_REG)) hazard2 = 1'b0;
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign write_count = cnt_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port among N_REQ writeback requesters, e.g. ALU result, memory load and link-address writes in the multi-cycle core.
- Each requester uses a valid/ready handshake. Requesters are granted round-robin, and the granted write passes through one registered output stage that drives the register file's write port directly.
- Also gives the control FSM read-hazard flags, so it can stall while a write to a source register is still in flight.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- CNT_W, 16, width of the saturating write counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*ADDR_W  destination register per requester; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  write data per requester, packed the same way.
- req_ready  out  N_REQ  one-hot grant; a transfer happens when valid and ready are both high at a clock edge.
- hold  in  1  when high, no grant is issued; the output stage still drains.
- rd_addr1  in  ADDR_W  source register 1 of the instruction being decoded.
- rd_addr2  in  ADDR_W  source register 2 of the instruction being decoded.
- hazard1  out  1  a write to rd_addr1 is pending.
- hazard2  out  1  a write to rd_addr2 is pending.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- write_count  out  CNT_W  number of register-file writes issued, saturating.

Behaviour:
- Reset (synchronous; wins over all other activity):
  - rf_we=0, rf_waddr=0, rf_wdata=0, write_count=0, priority pointer ptr=0.
  - Any request in flight is dropped. Requesters must re-present it after reset.
- Grant (combinational):
  - If hold=0, choose the first i with req_valid[i]=1, searching cyclically from ptr. Only that req_ready[i]=1.
  - If hold=1 or no request is valid, req_ready=0.
  - req_ready never depends on rf_we, so back-to-back grants sustain 1 write per cycle.
- Pointer:
  - On a grant at index g, ptr <= g+1; when g = N_REQ-1 it wraps to 0.
  - If there is no grant, ptr is unchanged.
- Output stage:
  - On a grant at edge T, rf_waddr/rf_wdata are loaded from requester g, and rf_we=1 for the cycle after T. The register file commits that write at edge T+1.
  - Latency from handshake to commit is 1 cycle.
  - With no grant, rf_we <= 0 and rf_waddr/rf_wdata hold their values.
- Register 0:
  - A request with addr 0 is granted and consumed normally, and ptr advances.
  - The output stage loads rf_we=0, so no write is issued and write_count does not increment.
- write_count:
  - Increments by 1 each cycle in which rf_we=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Hazards (combinational):
  - hazardK = (rd_addrK != 0) AND (rd_addrK matches the address of any requester with req_valid=1, OR (rf_we=1 AND rd_addrK == rf_waddr)).
  - rd_addrK = 0 never raises a hazard.
- hold:
  - Applies only to granting. A write already loaded in the output stage still issues.
- Requester rules:
  - Once req_valid rises, addr and data must stay stable until the handshake completes. The arbiter does not check this; it is a protocol assertion for verification.
- Starvation:
  - Under continuous requests from all requesters, every requester is granted within N_REQ cycles of asserting valid.

Decomposition:
- Package regfile_arb_pkg holds the default widths (DATA_W, ADDR_W) and the ZERO_REG constant.
- Sub-module rr_arbiter (N: request vector + pointer in, one-hot grant + encoded index out, combinational) is natural. The top level keeps the pointer register, the output stage, the hazard logic and the counter.

Test Plan:
- Single write: reset, then req_valid=3'b001, addr=7, data=32'hDEADBEEF → req_ready=001 that cycle; next cycle rf_we=1, rf_waddr=7, rf_wdata=DEADBEEF; write_count=1 one cycle after that.
- Round-robin: all 3 valid continuously for 6 cycles from ptr=0 → grants 001,010,100,001,010,100; rf_we high 6 consecutive cycles.
- Register 0: requester 1 valid with addr=0, data=5 → granted, rf_we stays 0, write_count unchanged, ptr=2.
- Hold:
  - Requester 2 valid while hold=1 for 3 cycles → req_ready=0 throughout.
  - After hold falls, the grant occurs in the same cycle.
  - A write accepted in the cycle before hold rose still issues while hold=1.
- Hazards:
  - Requester 0 pending at addr=9, rd_addr1=9, rd_addr2=0 → hazard1=1, hazard2=0.
  - After the handshake, hazard1 stays 1 for the rf_we cycle, then drops to 0.
- Reset mid-operation and saturation:
  - Assert reset in the cycle rf_we=1 → next cycle rf_we=0 and write_count=0.
  - Force write_count near max (CNT_W=4 build), issue 20 writes → count stops at 15.
